mod_arith_unit: RTL and testbench
=================================

# mod_arith_unit

Modular arithmetic engine for the ECC datapath. It consumes the 32-bit operands assembled by the nibble-serial operand loader (prime, point coordinates, curve coefficient), and the point-arithmetic control issues one field operation at a time to it. It performs modular add, subtract and interleaved shift-add multiply over GF(p) and returns a fully reduced result with a single-cycle completion pulse.

## Interface
- WIDTH, 32, operand/result/prime width in bits
- clk  in  1  rising-edge clock
- rst  in  1  reset: one clock, synchronous, active-high
- start  in  1  request pulse; accepted only when busy=0
- op  in  2  0=ADD, 1=SUB, 2=MUL, 3=reserved
- a  in  WIDTH  operand A, sampled on accepted start
- b  in  WIDTH  operand B, sampled on accepted start
- prime  in  WIDTH  modulus p, sampled on accepted start; odd, p≥3
- busy  out  1  high whenever state≠IDLE
- done  out  1  one-cycle pulse; result valid from this cycle
- result  out  WIDTH  reduced result, held until next accepted start
- err  out  1  operand-range error flag, valid with done

## Operation
- States: IDLE, ADDSUB, MUL, DONE. Reset → IDLE; busy=0, done=0, result=0, err=0, all internal registers 0.
- IDLE: start=1 latches op, a, b, prime; op∈{0,1,3} → ADDSUB, op=2 → MUL with bit counter=WIDTH-1 and accumulator r=0.
- ADDSUB, one cycle: ADD: s=a+b (WIDTH+1 bits), subtract p if s≥p. SUB: a−b, add p on borrow. op=3: result=0. → DONE.
- MUL, MSB-first interleaved: each cycle r=2r mod p, then if b[counter]: r=r+a mod p. Each reduction is a single conditional subtract on a WIDTH+1-bit intermediate. On counter=0, write result=r and go → DONE; otherwise decrement the counter.
- DONE: done=1 for exactly this cycle → IDLE.
- start while busy=1 is ignored, with no effect on the in-flight operation. op, a, b and prime may change freely after acceptance.
- Inputs must satisfy a<p and b<p. The result is always in [0, p−1] for legal inputs.
- Synchronous rst at any point, including mid-MUL, aborts the operation. The block returns to the reset values on the next edge and produces no done pulse.

## Timing
- Accepted start at edge t: busy=1 from t+1.
- ADD/SUB/reserved: done and result at t+2; busy=0 at t+3; the earliest next accept is at edge t+3.
- MUL: WIDTH iteration cycles t+1..t+WIDTH; done at t+WIDTH+1 (t+33 for WIDTH=32).
- result changes only in the cycle done rises (or on reset).

## Configuration
- MOD_OPERAND_CHECK_EN defined: on accept, if a≥p or b≥p, the unit goes straight to DONE. done is at t+2, result=0, err=1. No MUL iterations are performed. err=0 for legal operands.
- Not defined: err is tied 0, no comparison logic is built, and the result for out-of-range operands is unspecified.

## Structure
- Shared package ecc_pkg holds the WIDTH default constant, the op encoding constants (OP_ADD, OP_SUB, OP_MUL), and the state encoding. The operand loader and control reuse these.
- One sub-module, mod_cond_sub: a combinational (WIDTH+1)-bit value and p in, value mod p out (single conditional subtract). It is instantiated for the ADD path and for both MUL reduction steps.

## Test plan
- p=23, ADD a=20 b=5 → done at t+2, result=2, then busy=0 at t+3.
- p=23, SUB a=3 b=7 → result=19; SUB a=7 b=7 → result=0.
- p=23, MUL a=7 b=9 → done at t+33, result=17; MUL a=0 b=22 → result=0.
- p=0xFFFFFFFB, MUL a=b=0xFFFFFFFA → result=1; ADD a=b=0xFFFFFFFA → result=0xFFFFFFF9 (carry-out path).
- Start a MUL, pulse start with different operands at t+5, then assert rst at t+10 → second start ignored, no done pulse, outputs back to reset values at t+11. A new ADD afterwards completes normally.
- With MOD_OPERAND_CHECK_EN: p=23, MUL a=30 b=2 → done at t+2, err=1, result=0. A legal op afterwards gives err=0.

Source files
------------

// File: rtl/ecc_pkg.sv
// ecc_pkg: definitions shared across the ECC datapath blocks.
//   WIDTH      default operand / modulus width in bits
//   OP_*       field-operation encoding driven by the point-arithmetic control
//   state_t    mod_arith_unit sequencer states
// This package has no ports.
package ecc_pkg;

    localparam int WIDTH = 32;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_RSV = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDSUB = 2'd1,
        ST_MUL    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mod_arith_unit_if.sv
// mod_arith_unit_if: request/response bundle between the point-arithmetic
// control (master) and the modular arithmetic unit (slave).
//   start/op/a/b/prime   request, driven by the master
//   busy/done/result/err response, driven by the slave
interface mod_arith_unit_if #(
    parameter int WIDTH = ecc_pkg::WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] prime;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        output start, op, a, b, prime,
        input  busy, done, result, err
    );

    modport slave (
        input  start, op, a, b, prime,
        output busy, done, result, err
    );
endinterface

// File: rtl/mod_cond_sub.sv
// mod_cond_sub: single conditional subtract, val mod p for val < 2p.
//   val  in  WIDTH+1  value to reduce
//   p    in  WIDTH    modulus
//   res  out WIDTH    reduced value in [0, p-1]
module mod_cond_sub #(
    parameter int WIDTH = ecc_pkg::WIDTH
) (
    input  logic [WIDTH:0]   val,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] res
);
    logic [WIDTH-1:0] diff;

    // When val >= p, val - p < p < 2^WIDTH, so the low WIDTH bits are exact.
    assign diff = val[WIDTH-1:0] - p;
    assign res  = (val >= {1'b0, p}) ? diff : val[WIDTH-1:0];
endmodule

// File: rtl/mod_arith_unit.sv
// mod_arith_unit: GF(p) add, subtract and MSB-first interleaved multiply.
//   clk   rising-edge clock
//   rst   synchronous active-high reset, aborts any operation in flight
//   bus   mod_arith_unit_if.slave: start/op/a/b/prime in,
//         busy/done/result/err out
// Optional build macro MOD_OPERAND_CHECK_EN: flags a>=p or b>=p on accept,
// returning result=0 with err=1 two cycles later. Without it err is tied 0.
module mod_arith_unit
    import ecc_pkg::*;
#(
    parameter int WIDTH = ecc_pkg::WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    mod_arith_unit_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] result_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] add_red;
    logic [WIDTH:0]   sub_diff;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] addsub_res;
    logic [WIDTH:0]   dbl_in;
    logic [WIDTH-1:0] dbl_red;
    logic [WIDTH:0]   madd_in;
    logic [WIDTH-1:0] madd_red;
    logic [WIDTH-1:0] acc_next;

    assign add_sum  = {1'b0, a_r} + {1'b0, b_r};
    assign sub_diff = {1'b0, a_r} - {1'b0, b_r};
    // Borrow out of the WIDTH+1-bit difference means a<b; adding p wraps back in range.
    assign sub_res  = sub_diff[WIDTH] ? (sub_diff[WIDTH-1:0] + p_r) : sub_diff[WIDTH-1:0];

    mod_cond_sub #(.WIDTH(WIDTH)) u_add_red (.val(add_sum), .p(p_r), .res(add_red));

    // Multiply step: r = 2r mod p, then r = r + a mod p when the current b bit is set.
    assign dbl_in  = {acc_r, 1'b0};
    mod_cond_sub #(.WIDTH(WIDTH)) u_dbl_red (.val(dbl_in), .p(p_r), .res(dbl_red));

    assign madd_in = {1'b0, dbl_red} + {1'b0, a_r};
    mod_cond_sub #(.WIDTH(WIDTH)) u_madd_red (.val(madd_in), .p(p_r), .res(madd_red));

    assign acc_next = b_r[cnt_r] ? madd_red : dbl_red;

`ifdef MOD_OPERAND_CHECK_EN
    logic bad_r;
    logic err_r;
    logic out_of_range;

    assign out_of_range = (bus.a >= bus.prime) || (bus.b >= bus.prime);
    assign bus.err      = err_r;
`else
    assign bus.err = 1'b0;
`endif

    always_comb begin
        addsub_res = '0;
        case (op_r)
            OP_ADD:  addsub_res = add_red;
            OP_SUB:  addsub_res = sub_res;
            default: addsub_res = '0;
        endcase
`ifdef MOD_OPERAND_CHECK_EN
        if (bad_r) addsub_res = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            p_r      <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            result_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef MOD_OPERAND_CHECK_EN
            bad_r    <= 1'b0;
            err_r    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        op_r   <= bus.op;
                        a_r    <= bus.a;
                        b_r    <= bus.b;
                        p_r    <= bus.prime;
                        acc_r  <= '0;
                        cnt_r  <= CNT_W'(WIDTH - 1);
                        busy_r <= 1'b1;
                        state  <= (bus.op == OP_MUL) ? ST_MUL : ST_ADDSUB;
`ifdef MOD_OPERAND_CHECK_EN
                        // Illegal operands skip the multiply and finish via the one-cycle path.
                        bad_r <= out_of_range;
                        if (out_of_range) state <= ST_ADDSUB;
`endif
                    end
                end
                ST_ADDSUB: begin
                    result_r <= addsub_res;
                    done_r   <= 1'b1;
                    state    <= ST_DONE;
`ifdef MOD_OPERAND_CHECK_EN
                    err_r    <= bad_r;
`endif
                end
                ST_MUL: begin
                    acc_r <= acc_next;
                    if (cnt_r == '0) begin
                        result_r <= acc_next;
                        done_r   <= 1'b1;
                        state    <= ST_DONE;
`ifdef MOD_OPERAND_CHECK_EN
                        err_r    <= 1'b0;
`endif
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
endmodule

// File: tb/tb_mod_arith_unit.sv
// tb_mod_arith_unit: scoreboard bench for mod_arith_unit.
// The driver issues operations and queues the expected result, err flag and
// done cycle computed with plain 64-bit modular arithmetic; a monitor pops and
// compares whenever done is seen. Build with MOD_OPERAND_CHECK_EN defined to
// also exercise the operand-range error path.
module tb_mod_arith_unit;
    import ecc_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          cyc;
    } exp_t;

`ifdef MOD_OPERAND_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mod_arith_unit_if #(.WIDTH(WIDTH)) bus ();

    mod_arith_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] p);
        logic [63:0] aa, bb, pp;
        aa = {32'd0, a};
        bb = {32'd0, b};
        pp = {32'd0, p};
        case (op)
            2'd0:    return 32'((aa + bb) % pp);
            2'd1:    return 32'((aa + pp - bb) % pp);
            2'd2:    return 32'((aa * bb) % pp);
            default: return 32'd0;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_done: done=1 with nothing outstanding at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("result", {32'd0, bus.result}, {32'd0, mon_e.res});
                chk("err", {63'd0, bus.err}, {63'd0, mon_e.err});
                chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    // Called just after a negedge with the unit idle. Returns after the cycle
    // following done, having checked busy and the held result there.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] p);
        exp_t e;
        bit   bad;
        int   guard;
        bad    = CHK_EN && ((a >= p) || (b >= p));
        e.res  = bad ? 32'd0 : ref_result(op, a, b, p);
        e.err  = bad;
        e.cyc  = cyc + ((bad || op != 2'd2) ? 2 : WIDTH + 1);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.prime = p;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.prime = $urandom;
        chk("busy_after_accept", {63'd0, bus.busy}, 64'd1);
        guard = 0;
        while (!bus.done && guard < 80) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.done) begin
            chk("done_timeout", 64'd0, 64'd1);
            sb.delete();
        end
        @(negedge clk);
        chk("busy_after_done", {63'd0, bus.busy}, 64'd0);
        chk("result_held", {32'd0, bus.result}, {32'd0, e.res});
    endtask

    initial begin
        logic [31:0] p, a, b;
        int          ndone;

        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        bus.prime = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("reset_done", {63'd0, bus.done}, 64'd0);
        chk("reset_result", {32'd0, bus.result}, 64'd0);
        chk("reset_err", {63'd0, bus.err}, 64'd0);

        // Directed cases
        run_op(OP_ADD, 32'd20, 32'd5, 32'd23);
        run_op(OP_SUB, 32'd3, 32'd7, 32'd23);
        run_op(OP_SUB, 32'd7, 32'd7, 32'd23);
        run_op(OP_MUL, 32'd7, 32'd9, 32'd23);
        run_op(OP_MUL, 32'd0, 32'd22, 32'd23);
        run_op(OP_MUL, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFB);
        run_op(OP_ADD, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFB);
        run_op(OP_SUB, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        run_op(OP_RSV, 32'd5, 32'd6, 32'd23);

        // Abort a multiply mid-flight; a start while busy must be ignored.
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a     = 32'd11;
        bus.b     = 32'd13;
        bus.prime = 32'd23;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.a     = 32'd1;
        bus.b     = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_mid_mul", {63'd0, bus.busy}, 64'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_done", {63'd0, bus.done}, 64'd0);
        chk("abort_result", {32'd0, bus.result}, 64'd0);
        chk("abort_err", {63'd0, bus.err}, 64'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        run_op(OP_ADD, 32'd20, 32'd5, 32'd23);

        if (CHK_EN) begin
            run_op(OP_MUL, 32'd30, 32'd2, 32'd23);
            run_op(OP_ADD, 32'd4, 32'd23, 32'd23);
            run_op(OP_MUL, 32'd7, 32'd9, 32'd23);
        end

        // Randomized legal operations, alternating small and full-width moduli
        for (int i = 0; i < 40; i++) begin
            if (i[0]) p = 32'($urandom_range(3, 255)) | 32'd1;
            else      p = $urandom | 32'd1;
            if (p < 32'd3) p = 32'd3;
            a = $urandom % p;
            b = $urandom % p;
            run_op(2'($urandom_range(0, 3)), a, b, p);
        end

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
